// File: rtl/display_seq.sv
`default_nettype none
// ============================================================================
// Module   : display_seq
// Purpose  : Display sequencer between the code encoder and the two-digit
//            seven-segment decoder. Each rising edge of `ready` queues one
//            4-bit code in a small circular FIFO. Queued codes are presented
//            one at a time on `code_out`, each for HOLD_CYCLES clocks, with no
//            gap between consecutive codes. The display is blanked when
//            nothing is queued.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH       - FIFO entries (power of two, 2..16)
//   HOLD_CYCLES - clocks each code is shown (>= 1)
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   code_in  in   [3:0] code sampled when a `ready` rising edge is seen
//   ready    in   entry strobe; only a 0->1 transition pushes
//   clear    in   synchronous flush of the queue, blanks the display
//   code_out out  [3:0] code driven to the segment decoder
//   blank    out  1 = decoder outputs forced dark
//   busy     out  1 while a code is being shown
//   full     out  queue holds DEPTH entries
//   drop     out  one-cycle pulse when a push is lost to a full queue
//   count    out  queued entries, not counting the code on display
// Build option:
//   DISPLAY_SEQ_HOLD_LAST_EN - when defined, the last code stays lit after
//   the queue drains instead of being blanked.
// ============================================================================
module display_seq #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               code_in,
  input  logic                     ready,
  input  logic                     clear,
  output logic [3:0]               code_out,
  output logic                     blank,
  output logic                     busy,
  output logic                     full,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  // A one-cycle hold would give a zero-width timer; keep at least one bit.
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [PW:0]   DEPTH_CNT  = (PW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      code_out_q, code_out_d;
  logic            blank_q, blank_d;
  logic            busy_q;
  logic            drop_q, drop_d;
  logic            ready_q;

  logic            push_req;
  logic            have_data;
  logic            timer_done;
  logic            pop;
  logic            push_ok;

  // Next-state and datapath control
  always_comb begin
    push_req   = ready & ~ready_q;
    have_data  = (count_q != '0);
    timer_done = (timer_q == '0);
    // Pop from IDLE at once, or back-to-back when the current hold expires.
    pop        = ~clear & have_data & ((state_q == IDLE) | timer_done);
    // A full queue still accepts a push when a slot frees in the same cycle.
    push_ok    = ~clear & push_req & ((count_q != DEPTH_CNT) | pop);
    // A push discarded by clear is not reported as a drop.
    drop_d     = ~clear & push_req & ~push_ok;

    state_d    = state_q;
    timer_d    = timer_q;
    code_out_d = code_out_q;
    blank_d    = blank_q;
    count_d    = count_q;

    if (clear) begin
      state_d = IDLE;
      timer_d = '0;
      blank_d = 1'b1;
      count_d = '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase

      if (pop) begin
        code_out_d = mem_q[rd_ptr_q];
        blank_d    = 1'b0;
        timer_d    = TIMER_LOAD;
        state_d    = SHOW;
      end else if (state_q == SHOW) begin
        if (!timer_done) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = IDLE;
`ifdef DISPLAY_SEQ_HOLD_LAST_EN
          blank_d = blank_q;
`else
          blank_d = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      code_out_q <= 4'h0;
      blank_q    <= 1'b1;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      // Starting high means a `ready` held through reset does not push.
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      code_out_q <= code_out_d;
      blank_q    <= blank_d;
      busy_q     <= (state_d == SHOW);
      drop_q     <= drop_d;
      ready_q    <= ready;
      if (clear) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push_ok) begin
          mem_q[wr_ptr_q] <= code_in;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

  assign code_out = code_out_q;
  assign blank    = blank_q;
  assign busy     = busy_q;
  assign drop     = drop_q;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_CNT);

endmodule
`default_nettype wire
